uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receiver with an on-chip receive FIFO. It sits between the board `rx` pin and the SoC bus peripheral and converts 8N1 frames at `BAUD_RATE` into bytes for the CPU. It flags framing errors and overruns as sticky status bits. It is the receive-side counterpart of the SoC's UART transmit path.

## Interface
- `CLOCK_FREQ`, 50000000: `clk` frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bits per second.
- `BUFFER_SIZE`, 32: FIFO depth in bytes.
  - Must be a power of two, ≥ 2.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `read_en` input, 1 bit: pops the FIFO head. Ignored when `rx_empty`.
- `clear_errors` input, 1 bit: clears `frame_error` and `overrun`.
- `rd_data` output, 8 bits: FIFO head (show-ahead). Valid while `!rx_empty`.
- `rx_empty` output, 1 bit: FIFO holds 0 bytes.
- `rx_full` output, 1 bit: FIFO holds `BUFFER_SIZE` bytes.
- `frame_error` output, 1 bit: sticky; a stop bit was sampled low.
- `overrun` output, 1 bit: sticky; a valid byte was dropped because the FIFO was full.
- `busy` output, 1 bit: the receive FSM is not in IDLE.

## Operation
- Divisor: `DIV = CLOCK_FREQ / BAUD_RATE`, integer truncation. `HALF = DIV / 2`. Elaboration fails if `DIV < 4`.
- `rx` passes through a 2-flop synchronizer, reset to 1. The FSM sees only the synchronized value, `rx_s`.
- FSM states:
  - IDLE: on `rx_s == 0`, load baud counter = 0 and go to START.
  - START: at count `HALF-1`, sample `rx_s`. If 1 (glitch), return to IDLE. If 0, clear the counter and go to DATA with bit index 0.
  - DATA: every `DIV` cycles, sample `rx_s` into shift register bit [index], LSB first. After index 7, go to STOP.
  - STOP: after `DIV` cycles, sample `rx_s`.
    - If 1 and the FIFO can accept, push the byte and go to IDLE.
    - If 1 and the FIFO is full, set `overrun`, drop the byte, and go to IDLE.
    - If 0, set `frame_error`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s == 1`, then go to IDLE. Prevents a break condition from re-triggering a frame.
- The baud counter is `$clog2(DIV)` bits wide and resets to 0 on every sample point.
- FIFO: circular buffer with read/write pointers and a count of `$clog2(BUFFER_SIZE)+1` bits. Pointers wrap modulo `BUFFER_SIZE`.
- Push and pop in the same cycle:
  - Both take effect and the count is unchanged.
  - When full, the simultaneous pop frees a slot, so the push is accepted and `overrun` is not set.
  - When empty, `read_en` is ignored. The push lands and `rx_empty` falls next cycle.
- `clear_errors` together with a new error event in the same cycle: the set wins.
- Reset mid-frame: the FSM returns to IDLE, the partial byte is lost, the FIFO is emptied, and flags clear.

## Timing
- Reset values:
  - `rx_empty` = 1, `rx_full` = 0.
  - `rd_data` = 0.
  - `frame_error` = 0, `overrun` = 0, `busy` = 0.
  - Synchronizer flops = 1.
- Falling edge on `rx` to `busy` high: 3 cycles (2 synchronizer + 1 FSM).
- Sample points relative to the cycle `rx_s` first reads 0:
  - Start check at `HALF`.
  - Data bit k at `HALF + (k+1)·DIV`.
  - Stop bit at `HALF + 9·DIV`.
- Stop-bit sample to FIFO write: the same clock edge. `rx_empty` falls and `rd_data` is valid 1 cycle later.
- `read_en` pops on its edge. The next `rd_data`, `rx_empty` and `rx_full` are valid the following cycle.
- `frame_error` and `overrun` assert 1 cycle after the stop sample. They hold until `clear_errors` or reset.
- Back-to-back frames: a new start bit is accepted starting the cycle after the return to IDLE, so there are no dead bit times.

## Structure
- Package `uart_pkg`:
  - Enum `uart_rx_state_t` {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - Function `baud_div(clock_freq, baud_rate)`.
  - Localparams for the 8-bit data width and the stop-bit count (1).
- Sub-module `uart_rx_fifo`: parameterized synchronous show-ahead FIFO (`DEPTH`, `WIDTH`).
  - Ports: `clk`, `rst_n`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`.
  - Reusable by the transmit path.

## Test plan
All tests use `CLOCK_FREQ=1000`, `BAUD_RATE=100` (`DIV=10`, `HALF=5`) and `BUFFER_SIZE=4`.
- Single frame 0xA5 with a good stop bit → `rd_data=0xA5`, `rx_empty` falls 1 cycle after the stop sample, `frame_error=0`.
- 0.3-bit-time low glitch on idle `rx` → FSM returns to IDLE, FIFO stays empty, no flags set.
- Frame 0x3C with the stop bit held low for 2 bit times → `frame_error=1`, FIFO empty. A following 0x55 frame is received correctly after `rx` returns high.
- Five frames 0x01..0x05 with no reads → `rx_full=1` after the 4th. `overrun=1` after the 5th. Popping yields 0x01..0x04. `clear_errors` drops `overrun`.
- FIFO full, with `read_en` asserted in the stop-sample cycle of a 5th frame 0x66 → no overrun, count stays 4, final pop order 0x02, 0x03, 0x04, 0x66.
- `rst_n` low during data bit 4 of a frame → all outputs return to reset values. The next complete frame 0x81 is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame constants and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  function automatic int unsigned baud_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; rd_data shows the head and reads as zero while empty.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
      else if (w_do_rd && !w_do_wr) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, receive FIFO and sticky error flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned BUFFER_SIZE = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       read_en,
  input  logic       clear_errors,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV  = baud_div(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam int unsigned IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  if (DIV < 4) begin : g_bad_div
    $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end
  if (BUFFER_SIZE < 2 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_depth
    $error("uart_receiver: BUFFER_SIZE must be a power of two >= 2");
  end
  if (STOP_BITS != 1) begin : g_bad_stop
    $error("uart_receiver: only one stop bit is supported");
  end

  uart_rx_state_t       r_state;
  uart_rx_state_t       w_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_fe;
  logic                 r_ovr;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_set_fe;
  logic                 w_set_ovr;
  logic                 w_can_accept;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // START checks at mid-bit; later states sample one full bit period apart.
  assign w_tick = (r_state == START) ? (r_cnt == HALF_M1) : (r_cnt == DIV_M1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (!w_rx_s) w_next = START;
      START:     if (w_tick) w_next = w_rx_s ? IDLE : DATA;
      DATA:      if (w_tick && r_idx == LAST_BIT) w_next = STOP;
      STOP:      if (w_tick) w_next = w_rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (w_rx_s) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  assign w_can_accept = !w_fifo_full || (read_en && !w_fifo_empty);

  always_comb begin
    w_push    = 1'b0;
    w_set_fe  = 1'b0;
    w_set_ovr = 1'b0;
    busy      = (r_state != IDLE);
    if (r_state == STOP && w_tick) begin
      w_push    = w_rx_s && w_can_accept;
      w_set_ovr = w_rx_s && !w_can_accept;
      w_set_fe  = !w_rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state == IDLE || r_state == WAIT_IDLE || w_tick) r_cnt <= '0;
      else                                                     r_cnt <= r_cnt + 1'b1;
      if (r_state == IDLE) r_idx <= '0;
      if (r_state == DATA && w_tick) begin
        r_shift[r_idx] <= w_rx_s;
        r_idx          <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fe  <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_set_fe)          r_fe <= 1'b1;
      else if (clear_errors) r_fe <= 1'b0;
      if (w_set_ovr)         r_ovr <= 1'b1;
      else if (clear_errors) r_ovr <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH(BUFFER_SIZE),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (w_push),
    .wr_data(r_shift),
    .rd_en  (read_en),
    .rd_data(rd_data),
    .empty  (w_fifo_empty),
    .full   (w_fifo_full)
  );

  assign rx_empty    = w_fifo_empty;
  assign rx_full     = w_fifo_full;
  assign frame_error = r_fe;
  assign overrun     = r_ovr;

endmodule
